mem_dma_engine: RTL and testbench

Single-channel word-copy DMA engine upstream of `memory_map` port B. It copies `len` 32-bit words from a source SRAM region to a destination SRAM region by driving the port's address, write-data and write-enable, and consuming its 1-cycle-latency read data. Destinations inside the MMIO window are refused, so register space is never overwritten. Port A stays with the core.

---
 rtl/mem_dma_engine_pkg.sv | 16 +
 rtl/mem_dma_engine_if.sv | 14 +
 rtl/mem_dma_engine_range_check.sv | 22 ++
 rtl/mem_dma_engine.sv | 103 ++++++++++
 tb/tb_mem_dma_engine.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dma_engine_pkg.sv
// Shared types and constants for the word-copy DMA engine.
// No logic; imported by the engine, its range checker and the memory-port interface users.
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CHK  = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } dma_state_e;

   localparam logic [15:0] MMIO_LIMIT_DEFAULT = 16'h1000;
   localparam logic [15:0] MMIO_RSVD          = 16'h0E00;

endpackage

// File: rtl/mem_dma_engine_if.sv
// Single-port SRAM access bundle (port B): address, write data, write enable, 1-cycle read data.
// master = DMA engine, slave = memory; no flow control, the memory always responds.
interface mem_dma_engine_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_q;

   modport master (output mem_addr, output mem_wdata, output mem_we, input mem_q);
   modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_q);
endinterface

// File: rtl/mem_dma_engine_range_check.sv
// Destination range check: reject if the start lies in the MMIO window or the last word wraps past the top.
// Purely combinational, zero latency, no backpressure.
module dma_range_check
   import dma_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] MMIO_LIMIT = MMIO_LIMIT_DEFAULT
)(
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [ADDR_WIDTH-1:0] len,
   output logic                  reject
);
   localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0] dst_end;

   // One extra bit so a range running past the top of memory shows up as a carry.
   always_comb begin
      dst_end = {1'b0, dst} + {1'b0, len} - ONE;
      reject  = (dst < MMIO_LIMIT) || dst_end[ADDR_WIDTH];
   end
endmodule

// File: rtl/mem_dma_engine.sv
// Single-channel word-copy DMA on memory port B: one word per two cycles (read, then write).
// done arrives 2*len+2 cycles after start; rejected or zero-length requests finish in cycle 2.
module mem_dma_engine
   import dma_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] MMIO_LIMIT = MMIO_LIMIT_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH-1:0] len,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] words_done,
   mem_dma_engine_if.master      mem
);
   dma_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, dst_q, len_q, words_done_q, wd_inc;
   logic                  error_q;
   logic                  reject;

   dma_range_check #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MMIO_LIMIT (MMIO_LIMIT)
   ) u_range_check (
      .dst    (dst_q),
      .len    (len_q),
      .reject (reject)
   );

   assign wd_inc = words_done_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CHK;
         CHK:     state_d = (reject || (len_q == '0)) ? DONE : RD;
         RD:      state_d = abort ? DONE : WR;
         // An abort seen in WR still lets this write land before finishing.
         WR:      state_d = (abort || (wd_inc == len_q)) ? DONE : RD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         words_done_q <= '0;
         error_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  src_q        <= src_addr;
                  dst_q        <= dst_addr;
                  len_q        <= len;
                  words_done_q <= '0;
                  error_q      <= 1'b0;
               end
            end
            CHK:     error_q      <= reject;
            WR:      words_done_q <= wd_inc;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy          = (state_q == RD) || (state_q == WR);
      done          = (state_q == DONE);
      error         = error_q;
      words_done    = words_done_q;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = {DATA_WIDTH{1'b0}};
      case (state_q)
         RD: mem.mem_addr = src_q + words_done_q;
         WR: begin
            mem.mem_addr  = dst_q + words_done_q;
            mem.mem_we    = 1'b1;
            mem.mem_wdata = mem.mem_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine: a transfer-level model predicts every cycle of each copy,
// a single negedge process compares the DUT against it, and literal checks pin memory and timing.
module tb_mem_dma_engine;
   import dma_pkg::*;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        error;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wd;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [15:0] src_addr, dst_addr, len;
   logic        busy, done, error;
   logic [15:0] words_done;

   logic [31:0] sram    [0:65535];
   logic [31:0] ref_mem [0:65535];

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc_ctr, done_seen, we_cnt, model_done_cyc;
   logic [15:0] m_wd;
   logic        m_err;

   mem_dma_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) mem ();

   mem_dma_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MMIO_LIMIT(16'h1000)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .words_done (words_done),
      .mem        (mem)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem.mem_we) sram[mem.mem_addr] <= mem.mem_wdata;
      mem.mem_q <= sram[mem.mem_addr];
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.busy  = busy;
         a.done  = done;
         a.error = error;
         a.we    = mem.mem_we;
         a.addr  = mem.mem_addr;
         a.wd    = words_done;
         a.wdata = mem.mem_we ? mem.mem_wdata : 32'h0;
         chk($sformatf("cycle%0d{busy,done,err,we,addr,wd,wdata}", cyc_ctr), a, e);
         if (done) done_seen = cyc_ctr;
         if (mem.mem_we) we_cnt++;
         cyc_ctr++;
      end
   end

   // Transfer-level prediction: cycle 2k+2 reads src+k, cycle 2k+3 writes dst+k, done after the last write.
   task automatic model_run(input int src, input int dst, input int n, input int abort_cyc, input int rst_cyc);
      exp_t e;
      int   dend, cyc;
      bit   rej, stop;
      e = '0; e.error = m_err; e.wd = m_wd; exp_q.push_back(e);
      e = '0; exp_q.push_back(e);
      dend = dst + n - 1;
      rej  = (dst < 'h1000) || (dend > 'hFFFF);
      m_err = rej;
      m_wd  = 16'h0;
      cyc   = 2;
      stop  = 1'b0;
      if (!rej && n != 0) begin
         for (int k = 0; k < n && !stop; k++) begin
            e = '0; e.busy = 1'b1; e.addr = 16'(src + k); e.wd = 16'(k);
            exp_q.push_back(e);
            if (cyc == rst_cyc) begin
               e = '0; exp_q.push_back(e);
               m_wd = 16'h0; m_err = 1'b0; model_done_cyc = -1;
               return;
            end
            if (cyc == abort_cyc) begin
               cyc++;
               stop = 1'b1;
            end else begin
               cyc++;
               e.addr = 16'(dst + k); e.we = 1'b1; e.wdata = ref_mem[16'(src + k)];
               exp_q.push_back(e);
               ref_mem[16'(dst + k)] = e.wdata;
               m_wd = 16'(k + 1);
               if (cyc == abort_cyc) stop = 1'b1;
               cyc++;
            end
         end
      end
      model_done_cyc = cyc;
      e = '0; e.done = 1'b1; e.error = m_err; e.wd = m_wd; exp_q.push_back(e);
      e = '0; e.error = m_err; e.wd = m_wd; exp_q.push_back(e);
   endtask

   task automatic run(input string name, input int src, input int dst, input int n,
                      input int abort_cyc, input int rst_cyc,
                      input int req_done, input bit req_err, input int req_wd, input int req_we);
      bit finished;
      @(posedge clk); #1;
      cyc_ctr = 0; done_seen = -1; we_cnt = 0;
      model_run(src, dst, n, abort_cyc, rst_cyc);
      start = 1'b1; src_addr = 16'(src); dst_addr = 16'(dst); len = 16'(n);
      finished = 1'b0;
      for (int c = 0; c < 200 && !finished; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = (c + 1 == abort_cyc);
         rst   = (c + 1 == rst_cyc);
         finished = (exp_q.size() == 0);
      end
      abort = 1'b0;
      rst   = 1'b0;
      if (!finished) begin
         chk({name, "_timeout"}, 1, 0);
         exp_q.delete();
      end
      chk({name, "_done_cycle"}, 128'(done_seen), 128'(req_done));
      chk({name, "_error"}, error, 128'(req_err));
      chk({name, "_words_done"}, words_done, 128'(req_wd));
      chk({name, "_we_cycles"}, 128'(we_cnt), 128'(req_we));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0;
      m_wd = '0; m_err = 1'b0; cyc_ctr = 0; done_seen = -1; we_cnt = 0;
      for (int i = 0; i < 65536; i++) begin
         sram[i]    = 32'hDEAD0000 | 32'(i);
         ref_mem[i] = 32'hDEAD0000 | 32'(i);
      end
      for (int i = 0; i < 4; i++) begin
         sram[16'h2000 + i]    = 32'hA0 + 32'(i);
         ref_mem[16'h2000 + i] = 32'hA0 + 32'(i);
         sram[16'h4000 + i]    = 32'hB0 + 32'(i);
         ref_mem[16'h4000 + i] = 32'hB0 + 32'(i);
      end
      sram[16'h0D00]    = 32'h12345678;
      ref_mem[16'h0D00] = 32'h12345678;

      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back('0);
      @(negedge clk); #1;
      chk("reset_wdata", mem.mem_wdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run("copy4", 'h2000, 'h3000, 4, -1, -1, 10, 1'b0, 4, 4);
      chk("copy4_model_done", 128'(model_done_cyc), 10);
      chk("copy4_m0", sram[16'h3000], 32'hA0);
      chk("copy4_m1", sram[16'h3001], 32'hA1);
      chk("copy4_m2", sram[16'h3002], 32'hA2);
      chk("copy4_m3", sram[16'h3003], 32'hA3);

      run("mmio_dst", 'h2000, 'h0D00, 1, -1, -1, 2, 1'b1, 0, 0);
      chk("mmio_reg_kept", sram[16'h0D00], 32'h12345678);

      run("wrap_rej", 'h2000, 'hFFFE, 4, -1, -1, 2, 1'b1, 0, 0);
      chk("wrap_model_done", 128'(model_done_cyc), 2);
      chk("wrap_rej_fffe", sram[16'hFFFE], 32'hDEADFFFE);

      run("top_ok", 'h2000, 'hFFFE, 2, -1, -1, 6, 1'b0, 2, 2);
      chk("top_ok_fffe", sram[16'hFFFE], 32'hA0);
      chk("top_ok_ffff", sram[16'hFFFF], 32'hA1);

      run("len0", 'h2000, 'h3000, 0, -1, -1, 2, 1'b0, 0, 0);

      run("abort_wr", 'h2000, 'h5000, 8, 7, -1, 8, 1'b0, 3, 3);
      chk("abort_wr_m2", sram[16'h5002], 32'hA2);
      chk("abort_wr_m3", sram[16'h5003], 32'hDEAD5003);
      chk("abort_wr_m7", sram[16'h5007], 32'hDEAD5007);

      run("abort_rd", 'h2000, 'h5800, 2, 2, -1, 3, 1'b0, 0, 0);
      chk("abort_rd_m0", sram[16'h5800], 32'hDEAD5800);

      run("rst_mid", 'h2000, 'h6000, 16, -1, 10, -1, 1'b0, 0, 4);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_m3", sram[16'h6003], 32'hA3);
      chk("rst_mid_m4", sram[16'h6004], 32'hDEAD6004);

      run("after_rst", 'h4000, 'h7000, 3, -1, -1, 8, 1'b0, 3, 3);
      chk("after_rst_m0", sram[16'h7000], 32'hB0);
      chk("after_rst_m2", sram[16'h7002], 32'hB2);

      run("src_wrap", 'hFFFF, 'h8000, 2, -1, -1, 6, 1'b0, 2, 2);
      chk("src_wrap_m0", sram[16'h8000], 32'hA1);
      chk("src_wrap_m1", sram[16'h8001], 32'hDEAD0000);

      begin
         int bad = 0;
         for (int i = 0; i < 65536; i++) if (sram[i] !== ref_mem[i]) bad++;
         chk("memory_image_mismatches", 128'(bad), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
